// File: rtl/snes_pkg.sv
// Shared constants and FSM encoding for the SNES multi-pad interface.
package snes_pkg;
  localparam int SNES_BITS = 16;
  localparam int SNES_BTNS = 12;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_UPDATE
  } snes_state_t;
endpackage

// File: rtl/snes_autorepeat.sv
// Per-pad button levels, press pulses and auto-repeat counters, advanced once per poll.
module snes_autorepeat
  import snes_pkg::*;
#(
  parameter int                   REPEAT_DELAY = 16,
  parameter int                   REPEAT_RATE  = 4,
  parameter logic [SNES_BTNS-1:0] REPEAT_MASK  = 12'h0F0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 upd,
  input  logic [SNES_BTNS-1:0] now,
  output logic [SNES_BTNS-1:0] lvl,
  output logic [SNES_BTNS-1:0] press
);
  logic [SNES_BTNS-1:0][5:0] cnt, cnt_nx;
  logic [SNES_BTNS-1:0]      press_nx;

  // The reload value keeps the counter below REPEAT_DELAY, so it never wraps.
  always_comb begin
    cnt_nx   = cnt;
    press_nx = '0;
    for (int i = 0; i < SNES_BTNS; i++) begin
      if (!now[i]) begin
        cnt_nx[i] = '0;
      end else if (!lvl[i]) begin
        press_nx[i] = 1'b1;
        cnt_nx[i]   = '0;
      end else if (REPEAT_MASK[i]) begin
        if (cnt[i] + 6'd1 == 6'(REPEAT_DELAY)) begin
          press_nx[i] = 1'b1;
          cnt_nx[i]   = 6'(REPEAT_DELAY - REPEAT_RATE);
        end else begin
          cnt_nx[i] = cnt[i] + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lvl   <= '0;
      press <= '0;
    end else begin
      press <= '0;
      if (upd) begin
        cnt   <= cnt_nx;
        lvl   <= now;
        press <= press_nx;
      end
    end
  end
endmodule

// File: rtl/snes_multi_if.sv
// Multi-pad SNES poller: shared clock/latch bus timing, per-pad sampling and presence detect.
module snes_multi_if
  import snes_pkg::*;
#(
  parameter int                   NUM_PADS     = 2,
  parameter int                   CLK_HZ       = 9_000_000,
  parameter int                   POLL_HZ      = 60,
  parameter int                   HALF_US      = 6,
  parameter int                   REPEAT_DELAY = 16,
  parameter int                   REPEAT_RATE  = 4,
  parameter logic [SNES_BTNS-1:0] REPEAT_MASK  = 12'h0F0
) (
  input  logic                          i_clk,
  input  logic                          i_res_n,
  output logic                          o_snes_clk,
  output logic                          o_snes_latch,
  input  logic [NUM_PADS-1:0]           i_snes_data,
  output logic [NUM_PADS*SNES_BTNS-1:0] o_btn_state,
  output logic [NUM_PADS*SNES_BTNS-1:0] o_btn_press,
  output logic [NUM_PADS-1:0]           o_pad_present,
  output logic                          o_state_en
);
  localparam int HALF_CYC = CLK_HZ / 1_000_000 * HALF_US;
  localparam int POLL_CYC = CLK_HZ / POLL_HZ;
  localparam int PW       = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int HW       = (2 * HALF_CYC > 1) ? $clog2(2 * HALF_CYC) : 1;

  snes_state_t   state, state_nx;
  logic [PW-1:0] poll_cnt;
  logic [HW-1:0] ph_cnt, ph_nx;
  logic [3:0]    slot, slot_nx;
  logic          poll_wrap, sample, upd;

  logic [NUM_PADS-1:0]                 sync1, sync2, pres_nx;
  logic [NUM_PADS-1:0][SNES_BITS-1:0]  shreg;
  logic [NUM_PADS-1:0][SNES_BTNS-1:0]  new_lvl, lvl, press;

  assign poll_wrap = (poll_cnt == PW'(POLL_CYC - 1));
  assign sample    = (state == ST_CLK_LO) && (ph_cnt == '0);
  assign upd       = (state == ST_UPDATE);

  // Free-running so the poll period does not depend on frame length.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) poll_cnt <= '0;
    else          poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph_cnt + HW'(1);
    slot_nx  = slot;
    case (state)
      ST_IDLE: begin
        ph_nx = '0;
        if (poll_wrap) state_nx = ST_LATCH;
      end
      ST_LATCH: if (ph_cnt == HW'(2 * HALF_CYC - 1)) begin
        state_nx = ST_CLK_LO;
        ph_nx    = '0;
        slot_nx  = '0;
      end
      ST_CLK_LO: if (ph_cnt == HW'(HALF_CYC - 1)) begin
        state_nx = ST_CLK_HI;
        ph_nx    = '0;
      end
      ST_CLK_HI: if (ph_cnt == HW'(HALF_CYC - 1)) begin
        ph_nx = '0;
        if (slot == 4'd15) begin
          state_nx = ST_UPDATE;
        end else begin
          state_nx = ST_CLK_LO;
          slot_nx  = slot + 4'd1;
        end
      end
      ST_UPDATE: begin
        state_nx = ST_IDLE;
        ph_nx    = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        ph_nx    = '0;
      end
    endcase
  end

  // Bus pins are registered from the next state to keep them glitch-free.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state        <= ST_IDLE;
      ph_cnt       <= '0;
      slot         <= '0;
      o_snes_clk   <= 1'b1;
      o_snes_latch <= 1'b0;
    end else begin
      state        <= state_nx;
      ph_cnt       <= ph_nx;
      slot         <= slot_nx;
      o_snes_clk   <= (state_nx != ST_CLK_LO);
      o_snes_latch <= (state_nx == ST_LATCH);
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync1 <= '0;
      sync2 <= '0;
      shreg <= '0;
    end else begin
      sync1 <= i_snes_data;
      sync2 <= sync1;
      if (sample)
        for (int p = 0; p < NUM_PADS; p++)
          shreg[p] <= {~sync2[p], shreg[p][SNES_BITS-1:1]};
    end
  end

  // A line stuck low reads as all ones after inversion: no pad attached.
  always_comb begin
    pres_nx = '0;
    new_lvl = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      pres_nx[p] = ~&shreg[p];
      new_lvl[p] = pres_nx[p] ? shreg[p][SNES_BTNS-1:0] : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      o_pad_present <= '0;
      o_state_en    <= 1'b0;
    end else begin
      o_state_en <= upd;
      if (upd) o_pad_present <= pres_nx;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    snes_autorepeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_MASK  (REPEAT_MASK)
    ) u_ar (
      .clk   (i_clk),
      .rst_n (i_res_n),
      .upd   (upd),
      .now   (new_lvl[p]),
      .lvl   (lvl[p]),
      .press (press[p])
    );
  end

  assign o_btn_state = lvl;
  assign o_btn_press = press;
endmodule

// File: tb/tb_snes_multi_if.sv
// Randomized bench for snes_multi_if: pad models on the bus, poll-level reference model.
module tb_snes_multi_if;
  localparam int NP    = 2;
  localparam int H     = 2;
  localparam int POLL  = 100;
  localparam int LAT   = 2 * H + 32 * H + 1;
  localparam int DELAY = 16;
  localparam int RATE  = 4;

  logic               clk = 1'b0;
  logic               res_n = 1'b1;
  logic               sclk, slatch, en;
  logic [NP-1:0]      sdata, pres;
  logic [NP*12-1:0]   st, pr;

  snes_multi_if #(
    .NUM_PADS(NP), .CLK_HZ(1_000_000), .POLL_HZ(10_000), .HALF_US(H),
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .REPEAT_MASK(12'h0F0)
  ) dut (
    .i_clk(clk), .i_res_n(res_n), .o_snes_clk(sclk), .o_snes_latch(slatch),
    .i_snes_data(sdata), .o_btn_state(st), .o_btn_press(pr),
    .o_pad_present(pres), .o_state_en(en)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pad models: parallel load on latch, next bit on each clock rise, active-low line.
  logic [15:0]   rep [NP];
  logic [NP-1:0] absent = '0;
  logic [4:0]    idx = '0;
  always @(posedge slatch or posedge sclk)
    if (slatch) idx = '0;
    else if (idx != 5'd16) idx = idx + 5'd1;
  always_comb
    for (int p = 0; p < NP; p++) sdata[p] = absent[p] ? 1'b0 : ~rep[p][idx[3:0]];

  // Bus timing monitor.
  int   t_lrise = 0, t_lrise_prev = 0, t_lfall = 0, t_cfall = 0, low_cnt = 0, bad_low = 0;
  logic latch_q = 1'b0, sclk_q = 1'b1;
  always @(negedge clk) begin
    if (slatch && !latch_q) begin
      t_lrise_prev = t_lrise; t_lrise = cyc; low_cnt = 0; bad_low = 0;
    end
    if (!slatch && latch_q) t_lfall = cyc;
    if (!sclk && sclk_q) t_cfall = cyc;
    if (sclk && !sclk_q) begin
      low_cnt++;
      if (cyc - t_cfall != H) bad_low++;
    end
    latch_q = slatch;
    sclk_q  = sclk;
  end

  // Reference model: count of consecutive polls each button has been held.
  int            held [NP][12];
  logic [11:0]   mask_v = 12'h0F0;
  logic [NP*12-1:0] exp_st, exp_pr, last_st, last_pr;
  logic [NP-1:0] exp_pres, last_pres;
  int            t_en = 0;

  task automatic clear_model();
    for (int p = 0; p < NP; p++) for (int b = 0; b < 12; b++) held[p][b] = 0;
  endtask

  task automatic run_poll(input string tag);
    int  n = 0;
    bit  pe, now;
    while (!en && n < 3 * POLL) begin @(negedge clk); n++; end
    if (!en) begin chk({tag, "_timeout"}, 0, 1); return; end
    t_en = cyc;
    for (int p = 0; p < NP; p++) begin
      pe = !absent[p] && (rep[p] != 16'hFFFF);
      exp_pres[p] = pe;
      for (int b = 0; b < 12; b++) begin
        now = pe && rep[p][b];
        held[p][b] = now ? held[p][b] + 1 : 0;
        exp_st[p*12+b] = now;
        exp_pr[p*12+b] = now && (held[p][b] == 1 ||
          (mask_v[b] && held[p][b] > DELAY && (held[p][b] - DELAY - 1) % RATE == 0));
      end
    end
    last_st = st; last_pr = pr; last_pres = pres;
    chk({tag, "_state"}, st, exp_st);
    chk({tag, "_press"}, pr, exp_pr);
    chk({tag, "_present"}, pres, exp_pres);
    @(negedge clk);
    chk({tag, "_hold"}, st, exp_st);
    chk({tag, "_pr_clr"}, pr, 0);
    chk({tag, "_en_clr"}, en, 0);
  endtask

  int t_rel = 0;

  initial begin
    rep[0] = '0; rep[1] = '0;
    clear_model();
    #2 res_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk", sclk, 1);
    chk("rst_latch", slatch, 0);
    chk("rst_state", st, 0);
    chk("rst_press", pr, 0);
    chk("rst_present", pres, 0);
    chk("rst_en", en, 0);

    rep[0] = 16'h0001;
    res_n = 1'b1; t_rel = cyc;
    run_poll("b_press");
    chk("first_latch", t_lrise - t_rel, POLL);
    chk("en_latency", t_en - t_lrise, LAT);
    chk("latch_width", t_lfall - t_lrise, 2 * H);
    chk("clk_lows", low_cnt, 16);
    chk("low_width", bad_low, 0);
    chk("b_pulse", last_pr, 24'h000001);

    rep[0] = '0;
    run_poll("b_rel");
    chk("b_rel_lvl", last_st[0], 0);
    chk("poll_period", t_lrise - t_lrise_prev, POLL);

    rep[0] = 16'h0008; rep[1] = 16'h0008;
    run_poll("start");
    chk("start_both", last_pr, 24'h008008);
    rep[0] = '0; rep[1] = '0;
    run_poll("idle");

    rep[1] = 16'h0040;
    for (int k = 1; k <= 30; k++) begin
      run_poll("left");
      chk("left_repeat", last_pr[18], (k == 1 || k == 17 || k == 21 || k == 25 || k == 29));
    end
    rep[1] = '0;
    run_poll("left_rel");

    rep[1] = 16'h0100;
    for (int k = 1; k <= 20; k++) begin
      run_poll("a_hold");
      chk("a_no_repeat", last_pr[20], k == 1);
    end

    rep[1] = '0; absent = 2'b10;
    run_poll("absent");
    chk("absent_present", last_pres, 2'b01);
    chk("absent_p1", {last_st[23:12], last_pr[23:12]}, 0);
    chk("absent_p0", last_st[11:0], 0);
    absent = '0;

    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(3) == 0) rep[p] = {4'h0, 12'($urandom)};
        absent[p] = ($urandom_range(15) == 0);
      end
      run_poll("rand");
    end
    absent = '0;

    rep[0] = 16'h0FFF; rep[1] = 16'h0001;
    begin
      int n = 0;
      while (!slatch && n < 3 * POLL) begin @(negedge clk); n++; end
      chk("mid_latch_seen", slatch, 1);
    end
    repeat (16 * H + 1) @(negedge clk);
    chk("mid_in_low", sclk, 0);
    res_n = 1'b0;
    #1;
    chk("mid_rst_clk", sclk, 1);
    chk("mid_rst_latch", slatch, 0);
    chk("mid_rst_state", st, 0);
    chk("mid_rst_press", pr, 0);
    chk("mid_rst_present", pres, 0);
    chk("mid_rst_en", en, 0);
    clear_model();
    @(negedge clk);
    res_n = 1'b1; t_rel = cyc;
    run_poll("post_rst");
    chk("post_rst_latch", t_lrise - t_rel, POLL);
    chk("post_rst_en", t_en - t_rel, POLL + LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
